mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master AXI4-Lite arbiter in front of a single memory controller port.
// One transaction in flight; grant is round-robin or fixed-priority to m0.
module mem_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic        CLK,
    input  logic        RSTb,

    input  logic        m0_axi_awvalid,
    output logic        m0_axi_awready,
    input  logic [31:0] m0_axi_awaddr,
    input  logic [2:0]  m0_axi_awprot,
    input  logic        m0_axi_wvalid,
    output logic        m0_axi_wready,
    input  logic [31:0] m0_axi_wdata,
    input  logic [3:0]  m0_axi_wstrb,
    output logic        m0_axi_bvalid,
    input  logic        m0_axi_bready,
    input  logic        m0_axi_arvalid,
    output logic        m0_axi_arready,
    input  logic [31:0] m0_axi_araddr,
    input  logic [2:0]  m0_axi_arprot,
    output logic        m0_axi_rvalid,
    input  logic        m0_axi_rready,
    output logic [31:0] m0_axi_rdata,

    input  logic        m1_axi_awvalid,
    output logic        m1_axi_awready,
    input  logic [31:0] m1_axi_awaddr,
    input  logic [2:0]  m1_axi_awprot,
    input  logic        m1_axi_wvalid,
    output logic        m1_axi_wready,
    input  logic [31:0] m1_axi_wdata,
    input  logic [3:0]  m1_axi_wstrb,
    output logic        m1_axi_bvalid,
    input  logic        m1_axi_bready,
    input  logic        m1_axi_arvalid,
    output logic        m1_axi_arready,
    input  logic [31:0] m1_axi_araddr,
    input  logic [2:0]  m1_axi_arprot,
    output logic        m1_axi_rvalid,
    input  logic        m1_axi_rready,
    output logic [31:0] m1_axi_rdata,

    output logic        s_axi_awvalid,
    input  logic        s_axi_awready,
    output logic [31:0] s_axi_awaddr,
    output logic [2:0]  s_axi_awprot,
    output logic        s_axi_wvalid,
    input  logic        s_axi_wready,
    output logic [31:0] s_axi_wdata,
    output logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_bvalid,
    output logic        s_axi_bready,
    output logic        s_axi_arvalid,
    input  logic        s_axi_arready,
    output logic [31:0] s_axi_araddr,
    output logic [2:0]  s_axi_arprot,
    input  logic        s_axi_rvalid,
    output logic        s_axi_rready,
    input  logic [31:0] s_axi_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e state_q;
    logic   g_q;
    logic   last_grant_q;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;

    logic req_0, req_1;
    logic grant_nxt;
    logic sel_arvalid;

    logic mg_arvalid, mg_awvalid, mg_wvalid, mg_rready, mg_bready;
    logic gr_arready, gr_awready, gr_wready, gr_rvalid, gr_bvalid;

    assign req_0 = m0_axi_arvalid | m0_axi_awvalid;
    assign req_1 = m1_axi_arvalid | m1_axi_awvalid;

    // On contention round-robin picks the master that did not win last time.
    always_comb begin
        grant_nxt = 1'b0;
        if (PRIO_MODE != 0) begin
            grant_nxt = ~req_0;
        end else if (req_0 && req_1) begin
            grant_nxt = ~last_grant_q;
        end else begin
            grant_nxt = req_1;
        end
    end

    assign sel_arvalid = grant_nxt ? m1_axi_arvalid : m0_axi_arvalid;

    assign mg_arvalid = g_q ? m1_axi_arvalid : m0_axi_arvalid;
    assign mg_awvalid = g_q ? m1_axi_awvalid : m0_axi_awvalid;
    assign mg_wvalid  = g_q ? m1_axi_wvalid  : m0_axi_wvalid;
    assign mg_rready  = g_q ? m1_axi_rready  : m0_axi_rready;
    assign mg_bready  = g_q ? m1_axi_bready  : m0_axi_bready;

    assign s_axi_awaddr = g_q ? m1_axi_awaddr : m0_axi_awaddr;
    assign s_axi_awprot = g_q ? m1_axi_awprot : m0_axi_awprot;
    assign s_axi_wdata  = g_q ? m1_axi_wdata  : m0_axi_wdata;
    assign s_axi_wstrb  = g_q ? m1_axi_wstrb  : m0_axi_wstrb;
    assign s_axi_araddr = g_q ? m1_axi_araddr : m0_axi_araddr;
    assign s_axi_arprot = g_q ? m1_axi_arprot : m0_axi_arprot;

    assign m0_axi_rdata = s_axi_rdata;
    assign m1_axi_rdata = s_axi_rdata;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q      <= StIdle;
            g_q          <= 1'b0;
            last_grant_q <= 1'b1;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_0 || req_1) begin
                        g_q          <= grant_nxt;
                        last_grant_q <= grant_nxt;
                        state_q      <= sel_arvalid ? StRead : StWrite;
                    end
                end
                StRead: begin
                    if (s_axi_arvalid && s_axi_arready) ar_done_q <= 1'b1;
                    if (s_axi_rvalid && s_axi_rready) begin
                        state_q   <= StIdle;
                        ar_done_q <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                StWrite: begin
                    if (s_axi_awvalid && s_axi_awready) aw_done_q <= 1'b1;
                    if (s_axi_wvalid && s_axi_wready)   w_done_q  <= 1'b1;
                    if (s_axi_bvalid && s_axi_bready) begin
                        state_q   <= StIdle;
                        ar_done_q <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Done flags mask each channel so it handshakes exactly once per transaction.
    always_comb begin
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_bready  = 1'b0;
        gr_arready    = 1'b0;
        gr_awready    = 1'b0;
        gr_wready     = 1'b0;
        gr_rvalid     = 1'b0;
        gr_bvalid     = 1'b0;
        case (state_q)
            StRead: begin
                s_axi_arvalid = mg_arvalid & ~ar_done_q;
                gr_arready    = s_axi_arready & ~ar_done_q;
                gr_rvalid     = s_axi_rvalid;
                s_axi_rready  = mg_rready;
            end
            StWrite: begin
                s_axi_awvalid = mg_awvalid & ~aw_done_q;
                gr_awready    = s_axi_awready & ~aw_done_q;
                s_axi_wvalid  = mg_wvalid & ~w_done_q;
                gr_wready     = s_axi_wready & ~w_done_q;
                gr_bvalid     = s_axi_bvalid;
                s_axi_bready  = mg_bready;
            end
            default: ;
        endcase
    end

    assign m0_axi_arready = gr_arready & ~g_q;
    assign m0_axi_awready = gr_awready & ~g_q;
    assign m0_axi_wready  = gr_wready  & ~g_q;
    assign m0_axi_rvalid  = gr_rvalid  & ~g_q;
    assign m0_axi_bvalid  = gr_bvalid  & ~g_q;
    assign m1_axi_arready = gr_arready & g_q;
    assign m1_axi_awready = gr_awready & g_q;
    assign m1_axi_wready  = gr_wready  & g_q;
    assign m1_axi_rvalid  = gr_rvalid  & g_q;
    assign m1_axi_bvalid  = gr_bvalid  & g_q;

endmodule
